// File: rtl/pixel_mixer.sv
// Pixel mixer: once the background, foreground and sprite engines report
// ready, sweep one row of pixel addresses across their shared read port,
// resolve layer priority and transparency per pixel, and write the winning
// {layer, palette, color} word into the row buffer.
module pixel_mixer #(
    parameter int ROW_WIDTH = 320,
    parameter int PIPE_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prep,
    input  logic        bgr_done,
    input  logic        fgr_done,
    input  logic        spr_done,
    output logic [8:0]  pixel_addr,
    input  logic [8:0]  bgr_pixel_data,
    input  logic [8:0]  fgr_pixel_data,
    input  logic [8:0]  spr_pixel_data,
    input  logic [1:0]  spr_pixel_prio,
    output logic [8:0]  rowbuf_wraddr,
    output logic [10:0] rowbuf_wrdata,
    output logic        rowbuf_wren,
    output logic        done
);

    localparam logic [8:0] LAST_ADDR = 9'(ROW_WIDTH - 1);
    localparam int         CNT_W     = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MIX,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  drain_cnt;
    logic              mix_active;
    logic              done_next;
    logic              pipe_valid [PIPE_LAT];
    logic [8:0]        pipe_addr  [PIPE_LAT];
    logic              bg_vis;
    logic              fg_vis;
    logic              spr_vis;
    logic [10:0]       mix_word;

    assign bg_vis  = (bgr_pixel_data[3:0] != 4'd0);
    assign fg_vis  = (fgr_pixel_data[3:0] != 4'd0);
    assign spr_vis = (spr_pixel_data[3:0] != 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; prep always restarts the row handshake, and the
    // engine done levels are only looked at from the cycle after prep
    always_comb begin
        next_state = state;
        if (prep) begin
            next_state = ST_WAIT;
        end else begin
            case (state)
                ST_IDLE:  next_state = ST_IDLE;
                ST_WAIT:  if (bgr_done && fgr_done && spr_done) next_state = ST_MIX;
                ST_MIX:   if (pixel_addr == LAST_ADDR) next_state = ST_DRAIN;
                ST_DRAIN: if (drain_cnt == CNT_W'(PIPE_LAT - 1)) next_state = ST_DONE;
                ST_DONE:  next_state = ST_DONE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode: which cycles issue a live address and when done is due
    always_comb begin
        mix_active = (state == ST_MIX);
        done_next  = (state == ST_DONE) && !prep;
    end

    // Counts the cycles spent waiting for the last reads to come back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN && !prep) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // Address sweep; restarts at zero on every prep and holds after the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= 9'd0;
        end else if (prep) begin
            pixel_addr <= 9'd0;
        end else if (mix_active && pixel_addr != LAST_ADDR) begin
            pixel_addr <= pixel_addr + 9'd1;
        end
    end

    // Tracks each issued address until its engine data becomes valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_addr[i]  <= 9'd0;
            end
        end else if (prep) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= mix_active;
            pipe_addr[0]  <= pixel_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
        end
    end

    // Layer resolution: the highest visible layer wins, the sprite being
    // slotted below bg, between bg and fg, or on top depending on its priority
    always_comb begin
        mix_word = 11'd0;
        if (spr_pixel_prio[1]) begin
            if (spr_vis)      mix_word = {2'b11, spr_pixel_data};
            else if (fg_vis)  mix_word = {2'b10, fgr_pixel_data};
            else if (bg_vis)  mix_word = {2'b01, bgr_pixel_data};
        end else if (spr_pixel_prio[0]) begin
            if (fg_vis)       mix_word = {2'b10, fgr_pixel_data};
            else if (spr_vis) mix_word = {2'b11, spr_pixel_data};
            else if (bg_vis)  mix_word = {2'b01, bgr_pixel_data};
        end else begin
            if (fg_vis)       mix_word = {2'b10, fgr_pixel_data};
            else if (bg_vis)  mix_word = {2'b01, bgr_pixel_data};
            else if (spr_vis) mix_word = {2'b11, spr_pixel_data};
        end
    end

    // Row buffer write port; an aborting prep suppresses any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowbuf_wren   <= 1'b0;
            rowbuf_wraddr <= 9'd0;
            rowbuf_wrdata <= 11'd0;
        end else begin
            rowbuf_wren <= pipe_valid[PIPE_LAT-1] && !prep;
            if (pipe_valid[PIPE_LAT-1]) begin
                rowbuf_wraddr <= pipe_addr[PIPE_LAT-1];
                rowbuf_wrdata <= mix_word;
            end
        end
    end

    // Row-complete flag, raised the cycle after the final write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= done_next;
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Bench for pixel_mixer: behavioural engines with a two-cycle read latency,
// a write-collecting monitor and a per-pixel layer-priority reference model.
module tb_pixel_mixer;

    localparam int ROW_WIDTH = 320;

    logic        clk;
    logic        rst_n;
    logic        prep;
    logic        bgr_done;
    logic        fgr_done;
    logic        spr_done;
    logic [8:0]  pixel_addr;
    logic [8:0]  bgr_pixel_data;
    logic [8:0]  fgr_pixel_data;
    logic [8:0]  spr_pixel_data;
    logic [1:0]  spr_pixel_prio;
    logic [8:0]  rowbuf_wraddr;
    logic [10:0] rowbuf_wrdata;
    logic        rowbuf_wren;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [8:0] bg_mem   [512];
    logic [8:0] fg_mem   [512];
    logic [8:0] spr_mem  [512];
    logic [1:0] prio_mem [512];
    logic [8:0] eng_addr;

    typedef struct {
        logic [8:0]  a;
        logic [10:0] d;
    } wr_t;
    wr_t wq[$];

    pixel_mixer #(.ROW_WIDTH(ROW_WIDTH), .PIPE_LAT(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .prep           (prep),
        .bgr_done       (bgr_done),
        .fgr_done       (fgr_done),
        .spr_done       (spr_done),
        .pixel_addr     (pixel_addr),
        .bgr_pixel_data (bgr_pixel_data),
        .fgr_pixel_data (fgr_pixel_data),
        .spr_pixel_data (spr_pixel_data),
        .spr_pixel_prio (spr_pixel_prio),
        .rowbuf_wraddr  (rowbuf_wraddr),
        .rowbuf_wrdata  (rowbuf_wrdata),
        .rowbuf_wren    (rowbuf_wren),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engines: address captured at one edge, data presented after the next
    always @(posedge clk) begin
        eng_addr       <= pixel_addr;
        bgr_pixel_data <= bg_mem[eng_addr];
        fgr_pixel_data <= fg_mem[eng_addr];
        spr_pixel_data <= spr_mem[eng_addr];
        spr_pixel_prio <= prio_mem[eng_addr];
    end

    // Collect every row buffer write
    always @(negedge clk) begin
        if (rowbuf_wren === 1'b1) wq.push_back('{rowbuf_wraddr, rowbuf_wrdata});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: order layers top to bottom, first visible one wins
    function automatic logic [10:0] refMix(input int i);
        logic [8:0] stack [3];
        logic [1:0] code  [3];
        case (prio_mem[i])
            2'b00: begin
                stack = '{fg_mem[i], bg_mem[i], spr_mem[i]};
                code  = '{2'b10, 2'b01, 2'b11};
            end
            2'b01: begin
                stack = '{fg_mem[i], spr_mem[i], bg_mem[i]};
                code  = '{2'b10, 2'b11, 2'b01};
            end
            default: begin
                stack = '{spr_mem[i], fg_mem[i], bg_mem[i]};
                code  = '{2'b11, 2'b10, 2'b01};
            end
        endcase
        for (int j = 0; j < 3; j++) begin
            if (stack[j][3:0] != 4'd0) return {code[j], stack[j]};
        end
        return 11'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Fill engine memories; roughly a third of colors transparent
    task automatic applyStimulus(input bit all_clear);
        for (int i = 0; i < 512; i++) begin
            bg_mem[i]   = 9'($urandom);
            fg_mem[i]   = 9'($urandom);
            spr_mem[i]  = 9'($urandom);
            prio_mem[i] = 2'($urandom);
            if (all_clear || $urandom_range(2) == 0) bg_mem[i][3:0] = 4'd0;
            if (all_clear || $urandom_range(2) == 0) fg_mem[i][3:0] = 4'd0;
            if (all_clear || $urandom_range(2) == 0) spr_mem[i][3:0] = 4'd0;
        end
    endtask

    task automatic startRow();
        bgr_done = 1'b0;
        fgr_done = 1'b0;
        spr_done = 1'b0;
        prep     = 1'b1;
        tick();
        prep = 1'b0;
        checkOutput("done_after_prep", done, 1'b0);
        repeat (4) tick();
        bgr_done = 1'b1;
        fgr_done = 1'b1;
        spr_done = 1'b1;
    endtask

    task automatic verifyRow(input string tag);
        int n;
        checkOutput({tag, "_count"}, wq.size(), ROW_WIDTH);
        n = (wq.size() < ROW_WIDTH) ? wq.size() : ROW_WIDTH;
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_wraddr"}, wq[i].a, i);
            checkOutput({tag, "_wrdata"}, wq[i].d, refMix(i));
        end
    endtask

    task automatic finishRow(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 800) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done"}, done, 1'b1);
        verifyRow(tag);
    endtask

    task automatic runRow(input string tag);
        wq.delete();
        startRow();
        finishRow(tag);
    endtask

    task automatic setPixel7(input logic [8:0] b, input logic [8:0] f,
                             input logic [8:0] s, input logic [1:0] p);
        bg_mem[7]   = b;
        fg_mem[7]   = f;
        spr_mem[7]  = s;
        prio_mem[7] = p;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        prep     = 1'b0;
        bgr_done = 1'b0;
        fgr_done = 1'b0;
        spr_done = 1'b0;
        applyStimulus(1'b0);
        repeat (3) tick();
        checkOutput("rst_pixel_addr", pixel_addr, 0);
        checkOutput("rst_wraddr", rowbuf_wraddr, 0);
        checkOutput("rst_wrdata", rowbuf_wrdata, 0);
        checkOutput("rst_wren", rowbuf_wren, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Main row with cycle-exact timing; bgr_done dropped mid-sweep
        $display("[TB] random row with timing checks");
        wq.delete();
        startRow();
        for (int k = 0; k < ROW_WIDTH; k++) begin
            tick();
            checkOutput("sweep_addr", pixel_addr, k);
            checkOutput("sweep_wren", rowbuf_wren, (k >= 3) ? 1 : 0);
            checkOutput("sweep_done", done, 0);
            if (k == 50) bgr_done = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput("tail_wren", rowbuf_wren, 1);
            checkOutput("tail_done", done, 0);
        end
        tick();
        checkOutput("final_done", done, 1);
        checkOutput("final_wren", rowbuf_wren, 0);
        verifyRow("row0");
        repeat (3) tick();
        checkOutput("done_held", done, 1);

        $display("[TB] all-transparent row");
        applyStimulus(1'b1);
        runRow("clear");

        $display("[TB] pixel 7 priority cases");
        applyStimulus(1'b0);
        setPixel7({5'd3, 4'd5}, {5'd4, 4'd0}, {5'd9, 4'd2}, 2'b00);
        runRow("p7_prio0");
        checkOutput("p7_prio0_const", wq[7].d, {2'b01, 5'd3, 4'd5});
        setPixel7({5'd3, 4'd5}, {5'd4, 4'd0}, {5'd9, 4'd2}, 2'b01);
        runRow("p7_prio1");
        checkOutput("p7_prio1_const", wq[7].d, {2'b11, 5'd9, 4'd2});
        setPixel7({5'd3, 4'd5}, {5'd4, 4'd6}, {5'd9, 4'd2}, 2'b01);
        runRow("p7_fg6");
        checkOutput("p7_fg6_const", wq[7].d, {2'b10, 5'd4, 4'd6});
        setPixel7({5'd3, 4'd5}, {5'd4, 4'd6}, {5'd9, 4'd2}, 2'b10);
        runRow("p7_prio2");
        checkOutput("p7_prio2_const", wq[7].d, {2'b11, 5'd9, 4'd2});

        // Stale dones in the prep cycle must not start the sweep
        $display("[TB] stale done masking");
        applyStimulus(1'b0);
        wq.delete();
        bgr_done = 1'b1;
        fgr_done = 1'b1;
        spr_done = 1'b1;
        prep     = 1'b1;
        tick();
        prep     = 1'b0;
        bgr_done = 1'b0;
        fgr_done = 1'b0;
        repeat (5) begin
            tick();
            checkOutput("stale_hold_addr", pixel_addr, 0);
        end
        bgr_done = 1'b1;
        repeat (3) begin
            tick();
            checkOutput("partial_hold_addr", pixel_addr, 0);
        end
        fgr_done = 1'b1;
        tick();
        checkOutput("mix_start_addr0", pixel_addr, 0);
        tick();
        checkOutput("mix_start_addr1", pixel_addr, 1);
        finishRow("stale");

        // Abort at address 100, then a complete fresh row
        $display("[TB] abort mid-row");
        applyStimulus(1'b0);
        wq.delete();
        startRow();
        n = 0;
        while (pixel_addr !== 9'd100 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("abort_reach100", pixel_addr, 100);
        prep = 1'b1;
        tick();
        prep = 1'b0;
        wq.delete();
        bgr_done = 1'b0;
        fgr_done = 1'b0;
        checkOutput("abort_addr", pixel_addr, 0);
        checkOutput("abort_wren", rowbuf_wren, 0);
        repeat (3) begin
            tick();
            checkOutput("abort_quiet", rowbuf_wren, 0);
        end
        bgr_done = 1'b1;
        fgr_done = 1'b1;
        finishRow("after_abort");

        // Asynchronous reset at address 200
        $display("[TB] reset mid-row");
        applyStimulus(1'b0);
        wq.delete();
        startRow();
        n = 0;
        while (pixel_addr !== 9'd200 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("reset_reach200", pixel_addr, 200);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_addr", pixel_addr, 0);
        checkOutput("mid_rst_wraddr", rowbuf_wraddr, 0);
        checkOutput("mid_rst_wrdata", rowbuf_wrdata, 0);
        checkOutput("mid_rst_wren", rowbuf_wren, 0);
        checkOutput("mid_rst_done", done, 0);
        wq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            checkOutput("post_rst_wren", rowbuf_wren, 0);
            checkOutput("post_rst_addr", pixel_addr, 0);
        end
        checkOutput("post_rst_writes", wq.size(), 0);
        runRow("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
